// File: rtl/spirose_sched_pkg.sv
// ============================================================================
// Module   : spirose_sched_pkg
// Purpose  : Shared constants and FSM state type for the slice scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spirose_sched_pkg;

  localparam int SLICES_PER_TURN = 256;
  localparam int PERIOD_W        = 24;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_RUN     = 2'd2
  } sched_state_t;

endpackage : spirose_sched_pkg

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : 2-FF synchronizer with a registered rising-edge pulse; the pulse
//            appears three clocks after the asynchronous input rises.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_detect (
  input  logic clk,
  input  logic nrst,
  input  logic async_in,
  output logic rise_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic r_pulse;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_meta   <= async_in;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_pulse  <= r_sync & ~r_sync_d;
    end
  end

  assign rise_pulse = r_pulse;

endmodule : sync_edge_detect

`default_nettype wire

// File: rtl/slice_scheduler.sv
// ============================================================================
// Module   : slice_scheduler
// Purpose  : Locks onto a rotation sync pulse, measures the revolution period
//            and issues SLICES_PER_TURN evenly spaced slices per turn.
//            Optional statistics outputs: define SLICE_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_scheduler #(
  parameter int SLICES_PER_TURN = spirose_sched_pkg::SLICES_PER_TURN,
  parameter int PERIOD_W        = spirose_sched_pkg::PERIOD_W,
  parameter int MIN_PERIOD      = 4 * SLICES_PER_TURN
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               position_sync,
  input  logic                               slice_ready,
  output logic                               slice_valid,
  output logic [$clog2(SLICES_PER_TURN)-1:0] slice_index,
  output logic                               turn_start,
  output logic                               blank,
  output logic                               overrun
`ifdef SLICE_SCHED_STATS_EN
  ,
  output logic [PERIOD_W-1:0]                turn_period,
  output logic [15:0]                        overrun_count
`endif
);

  import spirose_sched_pkg::*;

  localparam int                 c_idx_w      = $clog2(SLICES_PER_TURN);
  localparam logic [c_idx_w-1:0] c_idx_max    = c_idx_w'(SLICES_PER_TURN - 1);
  localparam logic [PERIOD_W:0]  c_acc_step   = (PERIOD_W + 1)'(SLICES_PER_TURN);
  localparam logic [PERIOD_W-1:0] c_min_period = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] c_cnt_max    = '1;

  sched_state_t        r_state;
  sched_state_t        w_state_next;

  logic [PERIOD_W-1:0] r_counter;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W:0]   r_acc;
  logic [PERIOD_W:0]   w_acc_sum;
  logic [c_idx_w-1:0]  r_index;
  logic                r_valid;
  logic                r_turn_start;
  logic                r_overrun;

  logic                w_edge;
  logic                w_timeout;
  logic                w_accept;
  logic                w_tick;
  logic                w_issue;
  logic                w_overrun_evt;
  logic                w_enter_idle;

  sync_edge_detect u_sync_edge (
    .clk        (clk),
    .nrst       (nrst),
    .async_in   (position_sync),
    .rise_pulse (w_edge)
  );

  // Timeout only matters while locked or measuring; in IDLE a saturated
  // counter must still let the first edge through.
  assign w_timeout = (r_counter == c_cnt_max) && (r_state != S_IDLE);
  assign w_accept  = w_edge && (r_counter >= c_min_period) && !w_timeout;

  // Phase accumulator: adds SLICES_PER_TURN per clock and wraps at the
  // period, so one tick every period/SLICES_PER_TURN clocks without a divider.
  assign w_acc_sum = r_acc + c_acc_step;
  assign w_tick    = (r_state == S_RUN) && !w_accept && (w_acc_sum >= {1'b0, r_period});

  // A tick at the saturated index produces no new slice.
  assign w_issue       = (w_accept && (r_state != S_IDLE)) || (w_tick && (r_index != c_idx_max));
  assign w_overrun_evt = w_issue && r_valid && !slice_ready;
  assign w_enter_idle  = (r_state != S_IDLE) && (w_state_next == S_IDLE);

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (w_timeout) begin
          w_state_next = S_IDLE;
        end else if (w_accept) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_timeout) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    blank = 1'b1;
    if (r_state == S_RUN) begin
      blank = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_counter    <= '0;
      r_period     <= '0;
      r_acc        <= '0;
      r_index      <= '0;
      r_valid      <= 1'b0;
      r_turn_start <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_turn_start <= w_accept;

      if (w_accept) begin
        r_counter <= '0;
      end else if (r_counter != c_cnt_max) begin
        r_counter <= r_counter + 1'b1;
      end

      if (w_accept) begin
        r_acc <= '0;
        if (r_state != S_IDLE) begin
          r_period <= r_counter + 1'b1;
          r_index  <= '0;
        end
      end else if (r_state == S_RUN) begin
        if (w_tick) begin
          r_acc <= w_acc_sum - {1'b0, r_period};
          if (r_index != c_idx_max) begin
            r_index <= r_index + 1'b1;
          end
        end else begin
          r_acc <= w_acc_sum;
        end
      end

      if (w_enter_idle) begin
        r_valid <= 1'b0;
      end else if (w_issue) begin
        r_valid <= 1'b1;
      end else if (r_valid && slice_ready) begin
        r_valid <= 1'b0;
      end

      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign slice_valid = r_valid;
  assign slice_index = r_index;
  assign turn_start  = r_turn_start;
  assign overrun     = r_overrun;

`ifdef SLICE_SCHED_STATS_EN
  logic [15:0] r_overrun_count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_overrun_count <= '0;
    end else if (w_overrun_evt && (r_overrun_count != 16'hFFFF)) begin
      r_overrun_count <= r_overrun_count + 16'd1;
    end
  end

  assign turn_period   = r_period;
  assign overrun_count = r_overrun_count;
`endif

endmodule : slice_scheduler

`default_nettype wire

// File: tb/tb_slice_scheduler.sv
// ============================================================================
// Module   : tb_slice_scheduler
// Purpose  : Directed self-checking bench for slice_scheduler (4 slices/turn,
//            10-bit period, MIN_PERIOD 16). Honours SLICE_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slice_scheduler;

  logic       clk = 1'b0;
  logic       nrst;
  logic       position_sync;
  logic       slice_ready;
  logic       slice_valid;
  logic [1:0] slice_index;
  logic       turn_start;
  logic       blank;
  logic       overrun;
`ifdef SLICE_SCHED_STATS_EN
  logic [9:0]  turn_period;
  logic [15:0] overrun_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t_a, t_b, t_c, t_d, t_f, t_g, t_h, t_i;
  int n_b, n_d, n_g;

  always #5 clk = ~clk;

  slice_scheduler #(
    .SLICES_PER_TURN (4),
    .PERIOD_W        (10),
    .MIN_PERIOD      (16)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .position_sync (position_sync),
    .slice_ready   (slice_ready),
    .slice_valid   (slice_valid),
    .slice_index   (slice_index),
    .turn_start    (turn_start),
    .blank         (blank),
    .overrun       (overrun)
`ifdef SLICE_SCHED_STATS_EN
    ,
    .turn_period   (turn_period),
    .overrun_count (overrun_count)
`endif
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raising the sync input at cycle t gives turn_start/index visible at t+4.
  initial begin
    nrst          = 1'b0;
    position_sync = 1'b0;
    slice_ready   = 1'b1;
    step(3);
    check("rst_blank", blank, 1);
    check("rst_valid", slice_valid, 0);
    check("rst_index", slice_index, 0);
    check("rst_turn_start", turn_start, 0);
    check("rst_overrun", overrun, 0);
    nrst = 1'b1;
    step(30);

    // First edge: IDLE -> MEASURE, still dark, no slice
    t_a = cyc;
    position_sync = 1'b1;
    step(4);
    position_sync = 1'b0;
    check("measure_blank", blank, 1);
    check("measure_valid", slice_valid, 0);

    // Second edge 400 clk later: lock, slice 0
    t_b = t_a + 400;
    run_to(t_b);
    position_sync = 1'b1;
    step(4);
    position_sync = 1'b0;
    n_b = cyc;
    check("lock_turn_start", turn_start, 1);
    check("lock_index", slice_index, 0);
    check("lock_valid", slice_valid, 1);
    check("lock_blank", blank, 0);
`ifdef SLICE_SCHED_STATS_EN
    check("lock_turn_period", turn_period, 400);
`endif
    step(1);
    check("lock_turn_start_1cyc", turn_start, 0);
    check("lock_valid_accepted", slice_valid, 0);

    // Glitch 12 clk after the accepted edge must be ignored
    run_to(t_b + 12);
    position_sync = 1'b1;
    step(4);
    position_sync = 1'b0;
    check("glitch_turn_start", turn_start, 0);
    check("glitch_index", slice_index, 0);

    run_to(n_b + 99);
    check("idx1_early", slice_index, 0);
    step(1);
    check("idx1", slice_index, 1);
    check("idx1_valid", slice_valid, 1);
    run_to(n_b + 200);
    check("idx2", slice_index, 2);
    run_to(n_b + 300);
    check("idx3", slice_index, 3);

    // Edge C coincides with the fourth accumulator tick: edge wins
    t_c = t_b + 400;
    run_to(t_c);
    position_sync = 1'b1;
    step(3);
    check("pre_c_index", slice_index, 3);
    step(1);
    position_sync = 1'b0;
    check("c_turn_start", turn_start, 1);
    check("c_index", slice_index, 0);
    check("c_valid", slice_valid, 1);
    step(1);
    check("c_single_pulse", turn_start, 0);
    check("c_single_slice", slice_valid, 0);

    // Edge D at 200 clk: period shrinks, slices every 50 clk
    t_d = t_c + 200;
    run_to(t_d);
    position_sync = 1'b1;
    step(4);
    position_sync = 1'b0;
    n_d = cyc;
    check("d_turn_start", turn_start, 1);
    check("d_index", slice_index, 0);
`ifdef SLICE_SCHED_STATS_EN
    check("d_turn_period", turn_period, 200);
`endif
    run_to(n_d + 10);
    slice_ready = 1'b0;
    run_to(n_d + 49);
    check("d_idx1_early", slice_index, 0);
    step(1);
    check("d_idx1", slice_index, 1);
    check("d_idx1_valid", slice_valid, 1);
    check("d_no_overrun", overrun, 0);
    run_to(n_d + 99);
    check("d_overrun_early", overrun, 0);
    step(1);
    check("ovr_index", slice_index, 2);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", slice_valid, 1);
`ifdef SLICE_SCHED_STATS_EN
    check("ovr_count", overrun_count, 1);
`endif
    step(1);
    slice_ready = 1'b1;
    step(1);
    check("ovr_valid_cleared", slice_valid, 0);
    check("ovr_sticky", overrun, 1);

    // Sync stops: index saturates, then timeout drops lock
    run_to(n_d + 120);
    slice_ready = 1'b0;
    run_to(n_d + 150);
    check("sat_idx3", slice_index, 3);
    check("sat_valid", slice_valid, 1);
    run_to(n_d + 250);
    check("sat_no_wrap", slice_index, 3);
    run_to(n_d + 1000);
    check("pre_timeout_blank", blank, 0);
    check("pre_timeout_valid", slice_valid, 1);
    run_to(n_d + 1030);
    check("timeout_blank", blank, 1);
    check("timeout_valid", slice_valid, 0);
    check("timeout_overrun_sticky", overrun, 1);

    // Relock from IDLE, then reset mid-RUN
    t_f = cyc;
    position_sync = 1'b1;
    step(4);
    position_sync = 1'b0;
    check("f_blank", blank, 1);
    t_g = t_f + 400;
    run_to(t_g);
    position_sync = 1'b1;
    step(4);
    position_sync = 1'b0;
    n_g = cyc;
    check("g_blank", blank, 0);
    check("g_turn_start", turn_start, 1);
    run_to(n_g + 150);
    check("g_index", slice_index, 1);
    check("g_valid", slice_valid, 1);
`ifdef SLICE_SCHED_STATS_EN
    check("g_overrun_count", overrun_count, 2);
`endif
    nrst = 1'b0;
    #1;
    check("async_rst_blank", blank, 1);
    check("async_rst_valid", slice_valid, 0);
    check("async_rst_index", slice_index, 0);
    check("async_rst_turn_start", turn_start, 0);
    check("async_rst_overrun", overrun, 0);
`ifdef SLICE_SCHED_STATS_EN
    check("async_rst_period", turn_period, 0);
    check("async_rst_count", overrun_count, 0);
`endif
    step(1);
    nrst = 1'b1;
    step(30);

    // Two fresh edges are needed before lock
    t_h = cyc;
    position_sync = 1'b1;
    step(4);
    position_sync = 1'b0;
    check("h_blank", blank, 1);
    check("h_valid", slice_valid, 0);
    t_i = t_h + 400;
    run_to(t_i);
    position_sync = 1'b1;
    step(3);
    check("pre_i_blank", blank, 1);
    step(1);
    position_sync = 1'b0;
    check("i_blank", blank, 0);
    check("i_turn_start", turn_start, 1);
    check("i_index", slice_index, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_slice_scheduler

`default_nettype wire

// File: doc/slice_scheduler.md
SLICE_SCHEDULER -- requirements
Module: slice_scheduler

Interface
REQ-001 Parameter SLICES_PER_TURN SHALL default to spirose_sched_pkg::SLICES_PER_TURN (256) and gives the number of slices per revolution, a power of two from 4 to 256.
REQ-002 Parameter PERIOD_W SHALL default to 24 and gives the width of the cycle counter and the period register.
REQ-003 Parameter MIN_PERIOD SHALL default to 4*SLICES_PER_TURN; sync edges that arrive sooner are treated as glitches.
REQ-004 clk  in  1  system clock (66 MHz).
REQ-005 nrst  in  1  reset, asynchronous and active-low.
REQ-006 position_sync  in  1  rotation sensor pulse; asynchronous to clk.
REQ-007 slice_ready  in  1  consumer (driver_ready) can accept a slice.
REQ-008 slice_valid  out  1  a slice is pending for the consumer.
REQ-009 slice_index  out  $clog2(SLICES_PER_TURN)  index of the pending or current slice.
REQ-010 turn_start  out  1  one-cycle pulse on every accepted sync edge.
REQ-011 blank  out  1  the display must be dark (no valid rotation lock).
REQ-012 overrun  out  1  sticky flag: a slice was replaced before the consumer accepted it.

Function
REQ-013 position_sync SHALL pass through a 2-FF synchronizer and a rising-edge detector; the internal edge pulse appears 3 clk after the input rises.
REQ-014 The FSM SHALL have three states:
- IDLE -> MEASURE on the first edge.
- MEASURE -> RUN on the next accepted edge.
- RUN -> IDLE on timeout.
- MEASURE -> IDLE on timeout.
REQ-015 The cycle counter SHALL clear on each accepted edge and otherwise increment; reaching 2^PERIOD_W-1 is a timeout.
REQ-016 An edge with counter < MIN_PERIOD SHALL be ignored: counter not cleared, no state change, no pulses.
REQ-017 On an accepted edge in MEASURE or RUN, the FSM SHALL:
- set period = counter+1;
- clear the phase accumulator;
- set slice_index=0;
- issue a slice and pulse turn_start.
REQ-018 In RUN, each cycle without an edge, the phase accumulator SHALL compute acc+SLICES_PER_TURN; if the sum >= period, then:
- acc = sum-period;
- slice_index increments;
- a slice is issued.
Otherwise acc = sum.
REQ-019 slice_index SHALL saturate at SLICES_PER_TURN-1 and never wrap; only an accepted edge returns it to 0.
REQ-020 The accumulator SHALL be PERIOD_W+1 bits wide, and no division SHALL be used.
REQ-021 Issuing a slice SHALL set slice_valid=1 on the next cycle.
REQ-022 slice_valid SHALL clear on a cycle with slice_valid && slice_ready, unless a new slice is issued in the same cycle.
REQ-023 If a slice is issued while slice_valid=1 and slice_ready=0, slice_index SHALL update and overrun SHALL set.
REQ-024 A simultaneous edge and accumulator tick SHALL produce a single slice with index 0; the edge wins.
REQ-025 blank SHALL be 1 in IDLE and MEASURE and 0 in RUN.
REQ-026 On entering IDLE, slice_valid SHALL drop to 0.

Reset
REQ-027 Asserting nrst SHALL asynchronously force the following:
- state = IDLE;
- counter, acc, period and slice_index = 0;
- slice_valid, turn_start and overrun = 0;
- blank = 1;
- synchronizer flops = 0.
REQ-028 Reset mid-turn SHALL discard the period; after release, a fresh MEASURE revolution is required before RUN.
REQ-029 overrun SHALL clear only on reset.

Configuration
REQ-030 With SLICE_SCHED_STATS_EN defined, the module SHALL add the following outputs:
- turn_period [PERIOD_W-1:0], the last latched period;
- overrun_count [15:0], the number of overrun events, saturating at 16'hFFFF and reset to 0.
REQ-031 Without SLICE_SCHED_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 spirose_sched_pkg SHALL hold:
- SLICES_PER_TURN;
- the default PERIOD_W;
- the FSM state enum typedef sched_state_t (S_IDLE, S_MEASURE, S_RUN).
REQ-033 One sub-module, sync_edge_detect (2-FF synchronizer plus rising-edge pulse, clk/nrst), SHALL be instantiated once.

Verification
REQ-034 SLICES=4, MIN_PERIOD=16, sync every 400 clk -> first edge: blank=1. Second edge: turn_start, index 0. Then indices 1, 2, 3 at 100-clk spacing; blank=0.
REQ-035 Glitch: edge 10 clk after an accepted edge -> ignored; no turn_start, index sequence unchanged, period unchanged.
REQ-036 Hold slice_ready=0 across two slice ticks -> slice_index shows the newer index and overrun=1 stays set. With STATS_EN, overrun_count=1.
REQ-037 Sync stops in RUN with PERIOD_W=10 -> at 1023 clk after the last edge: IDLE, blank=1, slice_valid=0. slice_index holds 3 (saturated, no wrap) before the timeout.
REQ-038 Period shrinks 400->200 -> slices spaced 50 clk after the new edge. Edge coinciding with a tick -> a single slice, index 0.
REQ-039 nrst low for 1 clk mid-RUN -> all outputs at reset values immediately. The next two edges are needed before blank=0.
